cordic_req_scheduler: RTL

- Shares one pipelined CORDIC core between two requesters.
- Each requester submits 32-bit command words: bits[15:0] are the angle or tan operand; bit[16] is arctan_en.
- Round-robin arbitration picks one command per cycle and issues it to the core's command/valid input.
- A tag shift register tracks the owner of each in-flight operation, so results are routed back to the correct requester through per-requester response FIFOs with credit-based flow control.

---
 rtl/cordic_req_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cordic_req_scheduler.sv
// cordic_req_scheduler
//   Shares one pipelined CORDIC core between two requesters. A round-robin
//   arbiter issues at most one command per cycle into a registered
//   command/strobe pair. A {valid, owner} tag shift register follows each
//   operation through the core so its result can be steered into the
//   owner's response FIFO. A requester is only granted while its in-flight
//   count plus its FIFO occupancy is below RESP_DEPTH, so the FIFOs can
//   never overflow.
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   reqN_cmd/valid/ready         requester N command handshake (ready = grant)
//   rspN_data/valid/ready        requester N response FIFO head and pop
//   core_cmd, core_valid_in      registered issue to the core
//   core_result, core_valid_out  result returning from the core
//   idle                         nothing in flight, FIFOs empty, no issue pending
//   sync_err                     sticky tag/result misalignment flag
module cordic_req_scheduler #(
  parameter int unsigned CMD_WIDTH    = 32,
  parameter int unsigned RESULT_WIDTH = 32,
  parameter int unsigned PIPE_LATENCY = 8,
  parameter int unsigned RESP_DEPTH   = 4,
  parameter int unsigned CNT_WIDTH    = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CMD_WIDTH-1:0]    req0_cmd,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [CMD_WIDTH-1:0]    req1_cmd,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  output logic [RESULT_WIDTH-1:0] rsp0_data,
  output logic                    rsp0_valid,
  input  logic                    rsp0_ready,
  output logic [RESULT_WIDTH-1:0] rsp1_data,
  output logic                    rsp1_valid,
  input  logic                    rsp1_ready,
  output logic [CMD_WIDTH-1:0]    core_cmd,
  output logic                    core_valid_in,
  input  logic [RESULT_WIDTH-1:0] core_result,
  input  logic                    core_valid_out,
  output logic                    idle,
  output logic                    sync_err
);

  localparam int unsigned PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int unsigned STAGES = PIPE_LATENCY + 1;
  localparam int unsigned SUM_W  = CNT_WIDTH + 1;

  logic [1:0]           req_valid, rsp_ready, rsp_valid;
  logic [1:0]           eligible, credit, grant, push, retire, pop;
  logic [CMD_WIDTH-1:0] req_cmd [2];
  logic                 tail_v, tail_o;

  // rr_q = 0 gives requester 0 priority when both are eligible
  logic                    rr_q, rr_d;
  logic                    core_valid_q, core_valid_d;
  logic [CMD_WIDTH-1:0]    core_cmd_q, core_cmd_d;
  logic                    err_q, err_d;
  logic [STAGES-1:0]       tag_v_q, tag_v_d, tag_o_q, tag_o_d;
  logic [CNT_WIDTH-1:0]    infl_q [2], infl_d [2];
  logic [CNT_WIDTH-1:0]    cnt_q  [2], cnt_d  [2];
  logic [PTR_W-1:0]        rd_q   [2], rd_d   [2];
  logic [PTR_W-1:0]        wr_q   [2], wr_d   [2];
  logic [RESULT_WIDTH-1:0] mem_q  [2][RESP_DEPTH];
  logic [RESULT_WIDTH-1:0] mem_d  [2][RESP_DEPTH];

  assign req_valid  = {req1_valid, req0_valid};
  assign rsp_ready  = {rsp1_ready, rsp0_ready};
  assign req_cmd[0] = req0_cmd;
  assign req_cmd[1] = req1_cmd;

  // The stage written at issue reaches the tail exactly when its result
  // is presented on core_valid_out.
  assign tail_v = tag_v_q[STAGES-1];
  assign tail_o = tag_o_q[STAGES-1];

  always_comb begin
    credit    = '0;
    rsp_valid = '0;
    pop       = '0;
    push      = '0;
    retire    = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      credit[i]    = (({1'b0, infl_q[i]} + {1'b0, cnt_q[i]}) < SUM_W'(RESP_DEPTH));
      rsp_valid[i] = (cnt_q[i] != '0);
      pop[i]       = rsp_valid[i] & rsp_ready[i];
      // A valid tail retires its tag whether or not the result showed up,
      // so a lost result cannot leak credit.
      retire[i]    = tail_v & (tail_o == (i == 1));
      push[i]      = retire[i] & core_valid_out;
    end
  end

  always_comb begin
    eligible = req_valid & credit & {2{~rst}};
    grant    = '0;
    rr_d     = rr_q;
    if (eligible == 2'b11) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end else begin
      grant = eligible;
    end
    if (grant[0]) begin
      rr_d = 1'b1;
    end else if (grant[1]) begin
      rr_d = 1'b0;
    end
  end

  always_comb begin
    core_valid_d = |grant;
    core_cmd_d   = core_cmd_q;
    if (grant[1]) begin
      core_cmd_d = req_cmd[1];
    end else if (grant[0]) begin
      core_cmd_d = req_cmd[0];
    end
    tag_v_d = {tag_v_q[STAGES-2:0], |grant};
    tag_o_d = {tag_o_q[STAGES-2:0], grant[1]};
    err_d   = err_q | (core_valid_out ^ tail_v);
    for (int unsigned i = 0; i < 2; i++) begin
      for (int unsigned j = 0; j < RESP_DEPTH; j++) begin
        mem_d[i][j] = mem_q[i][j];
      end
      wr_d[i] = wr_q[i];
      rd_d[i] = rd_q[i];
      if (push[i]) begin
        mem_d[i][wr_q[i]] = core_result;
        wr_d[i]           = wr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rd_d[i] = rd_q[i] + 1'b1;
      end
      cnt_d[i]  = cnt_q[i] + CNT_WIDTH'(push[i]) - CNT_WIDTH'(pop[i]);
      infl_d[i] = infl_q[i] + CNT_WIDTH'(grant[i]) - CNT_WIDTH'(retire[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= 1'b0;
      core_valid_q <= 1'b0;
      core_cmd_q   <= '0;
      err_q        <= 1'b0;
      tag_v_q      <= '0;
      tag_o_q      <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        infl_q[i] <= '0;
        cnt_q[i]  <= '0;
        rd_q[i]   <= '0;
        wr_q[i]   <= '0;
        for (int unsigned j = 0; j < RESP_DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
    end else begin
      rr_q         <= rr_d;
      core_valid_q <= core_valid_d;
      core_cmd_q   <= core_cmd_d;
      err_q        <= err_d;
      tag_v_q      <= tag_v_d;
      tag_o_q      <= tag_o_d;
      for (int unsigned i = 0; i < 2; i++) begin
        infl_q[i] <= infl_d[i];
        cnt_q[i]  <= cnt_d[i];
        rd_q[i]   <= rd_d[i];
        wr_q[i]   <= wr_d[i];
        for (int unsigned j = 0; j < RESP_DEPTH; j++) begin
          mem_q[i][j] <= mem_d[i][j];
        end
      end
    end
  end

  assign req0_ready    = grant[0];
  assign req1_ready    = grant[1];
  assign rsp0_data     = mem_q[0][rd_q[0]];
  assign rsp1_data     = mem_q[1][rd_q[1]];
  assign rsp0_valid    = rsp_valid[0];
  assign rsp1_valid    = rsp_valid[1];
  assign core_cmd      = core_cmd_q;
  assign core_valid_in = core_valid_q;
  assign sync_err      = err_q;
  assign idle          = (infl_q[0] == '0) && (infl_q[1] == '0) &&
                         (cnt_q[0] == '0) && (cnt_q[1] == '0) && !core_valid_q;

endmodule
